// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Sequences the pipeline redirect after a branch resolves in EX. It compares
//   the branch unit's resolved decision with what fetch predicted. On a
//   mispredict it kills the younger instructions and holds a registered
//   redirect toward fetch until fetch accepts it. After acceptance it squashes
//   one stale in-flight fetch response.
//
// Optional feature: define BRANCH_PERF_CNT_EN to build the branch and
//   mispredict performance counters. Without it both counter outputs are
//   tied to 0 and no counter flops exist.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   i_ex_valid          EX stage holds a live instruction
//   i_branch            resolved taken flag
//   i_branch_addr       resolved target
//   i_ex_pc             PC of the EX instruction
//   i_pred_taken        fetch predicted taken
//   i_pred_target       fetch predicted target
//   i_fetch_ready       fetch accepts a redirect this cycle
//   o_redirect_valid    redirect request to fetch
//   o_redirect_pc       redirect PC (registered)
//   o_flush_if          kill the instruction entering IF/ID
//   o_flush_id          kill the instruction entering ID/EX
//   o_busy              controller is not in IDLE
//   o_branch_cnt        resolved control transfers
//   o_mispredict_cnt    mispredictions
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | watching EX; a mispredict flushes and latches the target
// REDIRECT | redirect held toward fetch until it is accepted
// DRAIN    | one cycle squashing the stale instruction-memory response

module branch_redirect_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ex_valid,
  input  logic            i_branch,
  input  logic [XLEN-1:0] i_branch_addr,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_target,
  input  logic            i_fetch_ready,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush_if,
  output logic            o_flush_id,
  output logic            o_busy,
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_mispredict_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] correct_target;
  logic [XLEN-1:0] redirect_target;
  logic            in_idle;
  logic            mispredict;
  logic            resolved;

  assign in_idle = (state_q == IDLE);

  // Branch inputs only matter in IDLE; EX holds a bubble in the other states.
  assign mispredict = in_idle & i_ex_valid &
                      ((i_branch != i_pred_taken) |
                       (i_branch & i_pred_taken & (i_branch_addr != i_pred_target)));

  assign resolved = in_idle & i_ex_valid & (i_branch | i_pred_taken);

  // The fall-through adds wrap modulo 2^XLEN. Bit 0 is cleared as JALR requires.
  assign correct_target  = i_branch ? i_branch_addr : (i_ex_pc + XLEN'(4));
  assign redirect_target = correct_target & ~(XLEN'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (mispredict) target_q <= redirect_target;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mispredict) state_d = REDIRECT;
      REDIRECT: if (i_fetch_ready) state_d = DRAIN;
      DRAIN:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    o_redirect_valid = 1'b0;
    o_flush_if       = 1'b0;
    o_flush_id       = 1'b0;
    case (state_q)
      IDLE: begin
        o_flush_if = mispredict;
        o_flush_id = mispredict;
      end
      REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_flush_if       = 1'b1;
        o_flush_id       = 1'b1;
      end
      DRAIN: begin
        o_flush_if = 1'b1;
      end
      default: begin
        o_redirect_valid = 1'b0;
      end
    endcase
  end

  assign o_redirect_pc = target_q;
  assign o_busy        = ~in_idle;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (resolved)   branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign o_branch_cnt     = branch_cnt_q;
  assign o_mispredict_cnt = mispredict_cnt_q;
`else
  logic unused_resolved;
  assign unused_resolved  = resolved;
  assign o_branch_cnt     = 32'd0;
  assign o_mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ex_valid;
  logic        i_branch;
  logic [31:0] i_branch_addr;
  logic [31:0] i_ex_pc;
  logic        i_pred_taken;
  logic [31:0] i_pred_target;
  logic        i_fetch_ready;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_flush_if;
  logic        o_flush_id;
  logic        o_busy;
  logic [31:0] o_branch_cnt;
  logic [31:0] o_mispredict_cnt;

  branch_redirect_ctrl #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_ex_valid       (i_ex_valid),
    .i_branch         (i_branch),
    .i_branch_addr    (i_branch_addr),
    .i_ex_pc          (i_ex_pc),
    .i_pred_taken     (i_pred_taken),
    .i_pred_target    (i_pred_target),
    .i_fetch_ready    (i_fetch_ready),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_flush_if       (o_flush_if),
    .o_flush_id       (o_flush_id),
    .o_busy           (o_busy),
    .o_branch_cnt     (o_branch_cnt),
    .o_mispredict_cnt (o_mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ex_valid;
    logic        branch;
    logic [31:0] baddr;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] ptgt;
    logic        exp_mis;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] exp_q[$];
  logic [31:0] bcnt;
  logic [31:0] mcnt;
  logic [31:0] held_pc;
  int          n_vec;
  int          n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic valid, input logic fif,
                         input logic fid, input logic busy);
    chk({name, "_valid"}, 32'(o_redirect_valid), 32'(valid));
    chk({name, "_flush_if"}, 32'(o_flush_if), 32'(fif));
    chk({name, "_flush_id"}, 32'(o_flush_id), 32'(fid));
    chk({name, "_busy"}, 32'(o_busy), 32'(busy));
  endtask

  task automatic chk_cnt(input string name);
`ifdef BRANCH_PERF_CNT_EN
    chk({name, "_branch_cnt"}, o_branch_cnt, bcnt);
    chk({name, "_mispredict_cnt"}, o_mispredict_cnt, mcnt);
`else
    chk({name, "_branch_cnt"}, o_branch_cnt, 32'd0);
    chk({name, "_mispredict_cnt"}, o_mispredict_cnt, 32'd0);
`endif
  endtask

  // Pops the scoreboard when the DUT presents a redirect.
  task automatic chk_redirect_pc(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_pc: got %h, want no redirect", name, o_redirect_pc);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_pc"}, o_redirect_pc, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic v, input logic br, input logic [31:0] ba,
                       input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
    i_ex_valid    = v;
    i_branch      = br;
    i_branch_addr = ba;
    i_ex_pc       = pc;
    i_pred_taken  = pt;
    i_pred_target = ptg;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic apply_vec(input int i);
    string nm;
    vec_t  v;
    v  = vecs[i];
    nm = $sformatf("v%0d", i);
    drive(v.ex_valid, v.branch, v.baddr, v.pc, v.pred_taken, v.ptgt);
    i_fetch_ready = 1'b1;
    if (v.exp_mis) exp_q.push_back(v.exp_pc);
    settle();
    chk_out({nm, "_detect"}, 1'b0, v.exp_mis, v.exp_mis, 1'b0);
    tick();
    if (v.ex_valid && (v.branch || v.pred_taken)) bcnt++;
    if (v.exp_mis) mcnt++;
    idle_inputs();
    settle();
    if (v.exp_mis) begin
      chk_out({nm, "_redirect"}, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_redirect_pc(nm);
      tick();
      settle();
      chk_out({nm, "_drain"}, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      settle();
    end
    chk_out({nm, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt(nm);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bcnt  = 0;
    mcnt  = 0;

    //          valid br   baddr          pc             pt   ptgt           mis  exp_pc
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0120, 32'h0000_0100, 1'b0, 32'h0,         1'b1, 32'h0000_0120};
    vecs[1] = '{1'b1, 1'b0, 32'h0,         32'h0000_0200, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0204};
    vecs[2] = '{1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0301, 32'h0000_0050, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0300};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0,         32'h0000_0500, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0700, 32'h0000_0600, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0406, 32'h0000_0380, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0406};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_1001, 32'h0000_0FF0, 1'b0, 32'h0,         1'b1, 32'h0000_1000};

    rst = 1'b1;
    i_fetch_ready = 1'b1;
    idle_inputs();
    tick();
    settle();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_pc", o_redirect_pc, 32'h0);
    chk_cnt("reset");
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Fetch stalls for 5 cycles: redirect and pc must hold steady.
    drive(1'b1, 1'b1, 32'h0000_0ABC, 32'h0000_0A00, 1'b0, 32'h0);
    i_fetch_ready = 1'b0;
    exp_q.push_back(32'h0000_0ABC);
    tick();
    bcnt++;
    mcnt++;
    idle_inputs();
    settle();
    chk_redirect_pc("stall");
    held_pc = 32'h0000_0ABC;
    for (int c = 0; c < 5; c++) begin
      chk_out($sformatf("stall_c%0d", c), 1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("stall_c%0d_pc", c), o_redirect_pc, held_pc);
      // Mispredicting inputs here must be ignored.
      drive(1'b1, 1'b1, 32'h0000_0DEF, 32'h0, 1'b0, 32'h0);
      tick();
      idle_inputs();
      settle();
    end
    i_fetch_ready = 1'b1;
    chk_out("stall_release", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("stall_release_pc", o_redirect_pc, held_pc);
    tick();
    settle();
    chk_out("stall_drain", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    settle();
    chk_out("stall_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("stall");

    // Mispredict held on the inputs: ignored in REDIRECT/DRAIN, re-evaluated at N+3.
    drive(1'b1, 1'b1, 32'h0000_0600, 32'h0000_0500, 1'b0, 32'h0);
    i_fetch_ready = 1'b1;
    exp_q.push_back(32'h0000_0600);
    settle();
    chk_out("b2b_n", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    bcnt++;
    mcnt++;
    settle();
    chk_out("b2b_n1", 1'b1, 1'b1, 1'b1, 1'b1);
    chk_redirect_pc("b2b_n1");
    tick();
    settle();
    chk_out("b2b_n2", 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(32'h0000_0600);
    tick();
    settle();
    chk_out("b2b_n3", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    bcnt++;
    mcnt++;
    idle_inputs();
    settle();
    chk_out("b2b_n4", 1'b1, 1'b1, 1'b1, 1'b1);
    chk_redirect_pc("b2b_n4");
    tick();
    settle();
    chk_out("b2b_n5", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    settle();
    chk_out("b2b_n6", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("b2b");

    // Reset in the third stalled REDIRECT cycle drops the pending redirect.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0900, 1'b1, 32'h0000_0F00);
    i_fetch_ready = 1'b0;
    exp_q.push_back(32'h0000_0904);
    tick();
    idle_inputs();
    settle();
    chk_out("rstmid_c1", 1'b1, 1'b1, 1'b1, 1'b1);
    chk_redirect_pc("rstmid_c1");
    tick();
    tick();
    rst = 1'b1;
    bcnt = 0;
    mcnt = 0;
    #1;
    chk_out("rstmid_async", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstmid_async_pc", o_redirect_pc, 32'h0);
    chk_cnt("rstmid_async");
    tick();
    rst = 1'b0;
    i_fetch_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      settle();
      chk_out($sformatf("rstmid_after%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_cnt("rstmid_after");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
